clk_rst_ctrl: RTL and testbench

- Parametrised clock-enable, reset-sequencing and run-control block for the CPU core on the board top level.
- Replaces the derived-clock divider, the fixed 8-bit power-on reset counter and the edge-clocked pause toggle with one block running entirely in the system clock domain.
- Outputs a single-cycle cpu_ce strobe at a programmable rate and a stretched cpu_reset.
- Takes debounced board buttons for pause/run toggle, single-step, and manual CPU reset.

---
 rtl/clk_rst_ctrl_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 89 ++++++++
 rtl/clk_rst_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_clk_rst_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : clk_rst_ctrl_pkg
//  Description : Shared helpers for the CPU clock-enable / reset / run-control
//                block. Provides the counter-width helper used to size the
//                divider, reset sequencer and debounce counters.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_rst_ctrl_pkg;

    // Width needed to hold the values 0..n-1. A one-state counter still
    // gets a single bit so that every counter is a legal vector.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : clk_rst_ctrl_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Synchronises a raw asynchronous button, normalises it so
//                that 1 means pressed, and accepts a new level only after it
//                has been held for DEBOUNCE_CYCLES consecutive clocks.
//                Emits a one-cycle pulse when the accepted level becomes
//                pressed; releases produce no pulse.
//  Ports       : clk         - system clock
//                reset       - synchronous active-high reset
//                btn_in      - raw button input (asynchronous)
//                pressed     - debounced level, 1 = pressed
//                press_pulse - one-cycle strobe on accepted press
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import clk_rst_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic pressed,
    output logic press_pulse
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Raw pin level of a released button.
    localparam logic             RELEASED_RAW = ACTIVE_LOW;

    logic             r_sync1_q;
    logic             r_sync2_q;
    logic             r_stable_q;
    logic             r_pulse_q;
    logic [CNT_W-1:0] r_cnt_q;

    logic             w_sync1_d;
    logic             w_sync2_d;
    logic             w_stable_d;
    logic             w_pulse_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_level;

    // Synchronised level with polarity folded out: 1 = pressed.
    assign w_level = r_sync2_q ^ ACTIVE_LOW;

    always_comb begin
        w_sync1_d  = btn_in;
        w_sync2_d  = r_sync1_q;
        w_stable_d = r_stable_q;
        w_pulse_d  = 1'b0;
        w_cnt_d    = '0;
        if (w_level != r_stable_q) begin
            if (r_cnt_q == CNT_LAST) begin
                // Held long enough: accept it. The counter returns to zero
                // because the levels agree again from the next cycle.
                w_stable_d = w_level;
                w_pulse_d  = w_level;
            end else begin
                w_cnt_d = r_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1_q  <= RELEASED_RAW;
            r_sync2_q  <= RELEASED_RAW;
            r_stable_q <= 1'b0;
            r_pulse_q  <= 1'b0;
            r_cnt_q    <= '0;
        end else begin
            r_sync1_q  <= w_sync1_d;
            r_sync2_q  <= w_sync2_d;
            r_stable_q <= w_stable_d;
            r_pulse_q  <= w_pulse_d;
            r_cnt_q    <= w_cnt_d;
        end
    end

    assign pressed     = r_stable_q;
    assign press_pulse = r_pulse_q;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/clk_rst_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : clk_rst_ctrl
//  Description : CPU clock-enable, reset-sequencing and run-control block.
//                Everything runs in the system clock domain: a divider makes
//                the tick strobe, a sequencer stretches cpu_reset over
//                RESET_TICKS ticks, and three debounced buttons provide
//                pause/run toggle, single step and manual CPU reset.
//  Ports       : clk          - system clock
//                reset        - synchronous active-high block reset
//                btn_pause    - raw button, toggles run/pause
//                btn_step     - raw button, single step while paused
//                btn_reset    - raw button, restarts the CPU reset sequence
//                cpu_ce       - one-cycle CPU clock-enable strobe
//                cpu_reset    - CPU reset, active high
//                tick         - raw divider strobe, never gated
//                running      - 1 = free-running, 0 = paused
//                step_pending - step accepted but not yet issued
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_rst_ctrl
    import clk_rst_ctrl_pkg::*;
#(
    parameter int SYS_CLK         = 50000000,
    parameter int CLK_OUT         = 1000000,
    parameter int RESET_TICKS     = 255,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter bit RUN_AT_RESET    = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_pause,
    input  logic btn_step,
    input  logic btn_reset,
    output logic cpu_ce,
    output logic cpu_reset,
    output logic tick,
    output logic running,
    output logic step_pending
);

    localparam int DIV   = SYS_CLK / CLK_OUT;
    localparam int DIV_W = cnt_width(DIV);
    localparam int RST_W = cnt_width(RESET_TICKS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_TICKS - 1);

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic w_pause_pulse;
    logic w_step_pulse;
    logic w_reset_pulse;
    logic w_pause_level;
    logic w_step_level;
    logic w_reset_level;
    // Only press events drive run control; the held levels are not needed.
    logic w_unused_levels;

    assign w_unused_levels = w_pause_level ^ w_step_level ^ w_reset_level;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (BTN_ACTIVE_LOW)
    ) u_db_pause (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_pause),
        .pressed     (w_pause_level),
        .press_pulse (w_pause_pulse)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (BTN_ACTIVE_LOW)
    ) u_db_step (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_step),
        .pressed     (w_step_level),
        .press_pulse (w_step_pulse)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (BTN_ACTIVE_LOW)
    ) u_db_reset (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_reset),
        .pressed     (w_reset_level),
        .press_pulse (w_reset_pulse)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div_q;
    logic             r_tick_q;
    logic [RST_W-1:0] r_rst_cnt_q;
    logic             r_cpu_reset_q;
    logic             r_running_q;
    logic             r_step_pending_q;

    logic [DIV_W-1:0] w_div_d;
    logic             w_tick_d;
    logic [RST_W-1:0] w_rst_cnt_d;
    logic             w_cpu_reset_d;
    logic             w_running_d;
    logic             w_step_pending_d;
    logic             w_step_fire;

    // Tick is registered off the next count so it is high exactly while
    // the counter holds DIV-1.
    always_comb begin
        w_div_d  = (r_div_q == DIV_LAST) ? '0 : r_div_q + 1'b1;
        w_tick_d = (w_div_d == DIV_LAST);
    end

    // Reset sequencer: a button press restarts the count even mid-sequence
    // and takes priority over a coincident tick.
    always_comb begin
        w_rst_cnt_d   = r_rst_cnt_q;
        w_cpu_reset_d = r_cpu_reset_q;
        if (w_reset_pulse) begin
            w_rst_cnt_d   = '0;
            w_cpu_reset_d = 1'b1;
        end else if (r_cpu_reset_q && r_tick_q) begin
            if (r_rst_cnt_q == RST_LAST) begin
                w_cpu_reset_d = 1'b0;
            end
            w_rst_cnt_d = r_rst_cnt_q + 1'b1;
        end
    end

    // A pending step is consumed only when it is the sole reason the
    // enable fires; during reset or while running it stays queued.
    assign w_step_fire = r_tick_q & r_step_pending_q & ~r_cpu_reset_q & ~r_running_q;

    // Run control: pause and reset presses both discard a pending step,
    // so a step press in the same cycle as either is dropped.
    always_comb begin
        w_running_d      = r_running_q ^ w_pause_pulse;
        w_step_pending_d = r_step_pending_q;
        if (w_reset_pulse || w_pause_pulse) begin
            w_step_pending_d = 1'b0;
        end else if (w_step_fire) begin
            w_step_pending_d = 1'b0;
        end else if (w_step_pulse && !r_running_q && !r_step_pending_q) begin
            w_step_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_q          <= '0;
            r_tick_q         <= 1'b0;
            r_rst_cnt_q      <= '0;
            r_cpu_reset_q    <= 1'b1;
            r_running_q      <= RUN_AT_RESET;
            r_step_pending_q <= 1'b0;
        end else begin
            r_div_q          <= w_div_d;
            r_tick_q         <= w_tick_d;
            r_rst_cnt_q      <= w_rst_cnt_d;
            r_cpu_reset_q    <= w_cpu_reset_d;
            r_running_q      <= w_running_d;
            r_step_pending_q <= w_step_pending_d;
        end
    end

    // Gated enable built only from flops, so it is as clean as tick.
    // The CPU always sees edges during reset, even while paused.
    assign cpu_ce       = r_tick_q & (r_cpu_reset_q | r_running_q | r_step_pending_q);
    assign cpu_reset    = r_cpu_reset_q;
    assign tick         = r_tick_q;
    assign running      = r_running_q;
    assign step_pending = r_step_pending_q;

endmodule : clk_rst_ctrl
`default_nettype wire

// File: tb/tb_clk_rst_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_clk_rst_ctrl
//  Description : Self-checking bench for clk_rst_ctrl (DIV=4, RESET_TICKS=3,
//                DEBOUNCE_CYCLES=4). Stimulus pushes the model's expected
//                per-cycle outputs into a queue; a monitor on the falling
//                edge pops and compares against the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_rst_ctrl;

    localparam int DIV_TB = 4;
    localparam int RT_TB  = 3;
    localparam int DB_TB  = 4;

    localparam bit [2:0] NONE = 3'b000;
    localparam bit [2:0] P    = 3'b001;
    localparam bit [2:0] S    = 3'b010;
    localparam bit [2:0] R    = 3'b100;

    logic clk;
    logic reset;
    logic btn_pause;
    logic btn_step;
    logic btn_reset;
    logic cpu_ce;
    logic cpu_reset;
    logic tick;
    logic running;
    logic step_pending;

    int n_cmp = 0;
    int n_mis = 0;

    logic [4:0] exp_q [$];

    clk_rst_ctrl #(
        .SYS_CLK         (8),
        .CLK_OUT         (2),
        .RESET_TICKS     (RT_TB),
        .DEBOUNCE_CYCLES (DB_TB),
        .BTN_ACTIVE_LOW  (1'b1),
        .RUN_AT_RESET    (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_pause    (btn_pause),
        .btn_step     (btn_step),
        .btn_reset    (btn_reset),
        .cpu_ce       (cpu_ce),
        .cpu_reset    (cpu_reset),
        .tick         (tick),
        .running      (running),
        .step_pending (step_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: cycles since reset, a tick countdown for the CPU
    // reset, and a window of raw button history per button.
    // Button index: 0 = pause, 1 = step, 2 = reset.
    // ------------------------------------------------------------------
    int unsigned m_n;
    int          m_left;
    bit          m_running;
    bit          m_pending;
    bit          m_stable [3];
    bit          m_pulse  [3];
    bit          m_hist   [3][DB_TB+2];

    // {cpu_ce, cpu_reset, tick, running, step_pending}
    function automatic logic [4:0] model_out();
        bit t;
        bit r;
        bit ce;
        t  = ((m_n % DIV_TB) == DIV_TB - 1);
        r  = (m_left > 0);
        ce = t && (r || m_running || m_pending);
        return {ce, r, t, m_running, m_pending};
    endfunction

    task automatic model_edge(input bit rst_i, input bit [2:0] prs);
        logic [4:0] o;
        bit         all_diff;
        if (rst_i) begin
            m_n       = 0;
            m_left    = RT_TB;
            m_running = 1'b1;
            m_pending = 1'b0;
            for (int b = 0; b < 3; b++) begin
                m_stable[b] = 1'b0;
                m_pulse[b]  = 1'b0;
                for (int k = 0; k < DB_TB + 2; k++) m_hist[b][k] = 1'b0;
            end
        end else begin
            o = model_out();
            if (m_pulse[2] || m_pulse[0])
                m_pending = 1'b0;
            else if (o[4] && m_pending && !o[3] && !m_running)
                m_pending = 1'b0;
            else if (m_pulse[1] && !m_running && !m_pending)
                m_pending = 1'b1;
            if (m_pulse[0]) m_running = !m_running;
            if (m_pulse[2])
                m_left = RT_TB;
            else if (o[2] && m_left > 0)
                m_left = m_left - 1;
            // A level is accepted once the synchronised input (two cycles
            // behind the pin) has disagreed with it for DB_TB cycles running.
            for (int b = 0; b < 3; b++) begin
                for (int k = DB_TB + 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
                m_hist[b][0] = prs[b];
                all_diff = 1'b1;
                for (int k = 2; k <= DB_TB + 1; k++)
                    if (m_hist[b][k] == m_stable[b]) all_diff = 1'b0;
                m_pulse[b] = all_diff && !m_stable[b];
                if (all_diff) m_stable[b] = !m_stable[b];
            end
            m_n = m_n + 1;
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive_cycle(input bit rst_i, input bit [2:0] prs);
        reset     = rst_i;
        btn_pause = ~prs[0];
        btn_step  = ~prs[1];
        btn_reset = ~prs[2];
        model_edge(rst_i, prs);
        @(posedge clk);
        #1;
        exp_q.push_back(model_out());
    endtask

    task automatic hold(input int n, input bit rst_i, input bit [2:0] prs);
        for (int i = 0; i < n; i++) drive_cycle(rst_i, prs);
    endtask

    initial begin
        bit [2:0] lvl;
        int       left [3];
        bit       rr;

        reset     = 1'b1;
        btn_pause = 1'b1;
        btn_step  = 1'b1;
        btn_reset = 1'b1;
        model_edge(1'b1, NONE);
        @(posedge clk);
        #1;
        exp_q.push_back(model_out());
        hold(1, 1'b1, NONE);

        // Power-on sequence, then pause held from cycle 20 for 10 cycles.
        hold(20, 1'b0, NONE);
        hold(10, 1'b0, P);
        hold(10, 1'b0, NONE);
        // Single step while paused.
        hold(6, 1'b0, S);
        hold(12, 1'b0, NONE);
        // Glitch on pause shorter than the debounce window.
        hold(3, 1'b0, P);
        hold(10, 1'b0, NONE);
        // Manual reset while paused, steps queued during the reset sequence.
        hold(6, 1'b0, R);
        hold(2, 1'b0, NONE);
        hold(5, 1'b0, S);
        hold(5, 1'b0, NONE);
        hold(5, 1'b0, S);
        hold(20, 1'b0, NONE);
        // Reset and step pressed together: step discarded.
        hold(6, 1'b0, R | S);
        hold(24, 1'b0, NONE);
        // Pause and step together while paused: resumes free running.
        hold(6, 1'b0, P | S);
        hold(20, 1'b0, NONE);
        // Manual reset landing mid power-on count (counter = 2).
        hold(2, 1'b1, NONE);
        hold(3, 1'b0, NONE);
        hold(6, 1'b0, R);
        hold(30, 1'b0, NONE);

        // Randomised button activity with occasional block resets.
        lvl = NONE;
        for (int b = 0; b < 3; b++) left[b] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (left[b] == 0) begin
                    lvl[b]  = 1'($urandom_range(0, 1));
                    left[b] = int'($urandom_range(1, 14));
                end
                left[b] = left[b] - 1;
            end
            rr = ($urandom_range(0, 599) == 0);
            drive_cycle(rr, lvl);
        end

        @(negedge clk);
        #1;
        n_cmp = n_cmp + 1;
        if (exp_q.size() != 0) begin
            n_mis = n_mis + 1;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // ------------------------------------------------------------------
    // Monitor: one expected output vector per cycle.
    // ------------------------------------------------------------------
    initial begin
        logic [4:0] exp_v;
        logic [4:0] act_v;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {cpu_ce, cpu_reset, tick, running, step_pending};
                n_cmp = n_cmp + 1;
                if (act_v !== exp_v) begin
                    n_mis = n_mis + 1;
                    $display("FAIL outputs @%0t {ce,rst,tick,run,step}: got %b required %b",
                             $time, act_v, exp_v);
                end
            end
        end
    end

endmodule : tb_clk_rst_ctrl
`default_nettype wire
